// File: rtl/sr595_frame_loader.sv
// Frame loader modelling N_CHIPS cascaded 74x595 shift/storage registers and their sequencer.
// Optional SR595_LSB_FIRST_EN shifts frames LSB first instead of MSB first.
module sr595_frame_loader #(
    parameter int N_CHIPS = 1,
    localparam int W = 8 * N_CHIPS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         abort,
    input  logic         oe_n,
    output logic [W-1:0] q,
    output logic         q_en,
    output logic         ser_out,
    output logic         done
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  tx;
    logic [W-1:0]  sr;
    logic [CW-1:0] cnt;
    logic [W-1:0]  q_reg;

    // Handshake: a frame transfers on an edge where in_valid && in_ready and abort is low.
    assign in_ready = (state == IDLE);
    assign q        = q_reg;
    assign q_en     = ~oe_n;

`ifdef SR595_LSB_FIRST_EN
    assign ser_out = sr[0];
`else
    assign ser_out = sr[W-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tx    <= '0;
            sr    <= '0;
            cnt   <= '0;
            q_reg <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                // Cancelling a frame keeps the previously latched outputs intact.
                state <= IDLE;
                sr    <= '0;
                tx    <= '0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (abort) begin
                            sr <= '0;
                        end else if (in_valid) begin
                            tx    <= in_data;
                            cnt   <= '0;
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
`ifdef SR595_LSB_FIRST_EN
                        sr <= {tx[0], sr[W-1:1]};
                        tx <= {1'b0, tx[W-1:1]};
`else
                        sr <= {sr[W-2:0], tx[W-1]};
                        tx <= {tx[W-2:0], 1'b0};
`endif
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(W - 1)) begin
                            state <= LATCH;
                        end
                    end
                    LATCH: begin
                        q_reg <= sr;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sr595_frame_loader.sv
// Directed and randomised frame tests for sr595_frame_loader with a latched-value scoreboard.
module tb_sr595_frame_loader;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         abort;
    logic         oe_n;
    logic [W-1:0] q;
    logic         q_en;
    logic         ser_out;
    logic         done;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    sr595_frame_loader #(.N_CHIPS(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .abort    (abort),
        .oe_n     (oe_n),
        .q        (q),
        .q_en     (q_en),
        .ser_out  (ser_out),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Position of the cascade output bit within the shift register.
    function automatic int ser_idx(input int step);
`ifdef SR595_LSB_FIRST_EN
        return step;
`else
        return W - 1 - step;
`endif
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("sb_q", q, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [W-1:0] a5;
        logic [W-1:0] f;
        rst      = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        abort    = 1'b0;
        oe_n     = 1'b1;
        a5       = 8'hA5;

        // Reset asserted mid-cycle takes effect immediately
        #3 rst = 1'b1;
        #1;
        check("rst_q", q, 0);
        check("rst_ser", ser_out, 0);
        check("rst_done", done, 0);
        check("rst_ready", in_ready, 1);
        check("q_en_off", q_en, 0);
        oe_n = 1'b0;
        #1;
        check("q_en_on", q_en, 1);
        #7 rst = 1'b0;
        tick();
        check("post_rst_q", q, 0);
        check("post_rst_ready", in_ready, 1);
        check("post_rst_ser", ser_out, 0);

        // Single frame 0xA5
        in_data = a5; in_valid = 1'b1; exp_q.push_back(a5);
        tick();
        in_valid = 1'b0;
        check("sf_ready_e0", in_ready, 0);
        for (int i = 1; i <= W; i++) begin
            tick();
            check("sf_ready_busy", in_ready, 0);
            check("sf_no_done", done, 0);
        end
        tick();
        check("sf_q", q, 32'hA5);
        check("sf_done", done, 1);
        check("sf_ready_e9", in_ready, 1);
        check("sf_ser", ser_out, a5[ser_idx(0)]);
        tick();
        check("sf_done_one_cycle", done, 0);

        // Back-to-back: 0xA5 then 0x3C with in_valid held
        in_data = a5; in_valid = 1'b1; exp_q.push_back(a5);
        tick();
        in_data = 8'h3C; exp_q.push_back(8'h3C);
        for (int i = 1; i <= W; i++) tick();
        check("bb_ready_busy_e8", in_ready, 0);
        tick();
        check("bb_ser_e9", ser_out, 1);
        check("bb_q1", q, 32'hA5);
        check("bb_ready_e9", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bb_accept_e10", in_ready, 0);
        for (int i = 1; i < W; i++) begin
            tick();
            check("bb_ser_step", ser_out, a5[ser_idx(i)]);
            check("bb_q_hold", q, 32'hA5);
        end
        tick();
        check("bb_q_before_latch", q, 32'hA5);
        tick();
        check("bb_q2", q, 32'h3C);
        check("bb_done2", done, 1);

        // Abort at e4 of frame 0xFF: nothing latched, shift register cleared
        tick();
        in_data = 8'hFF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_ready", in_ready, 1);
        check("ab_ser", ser_out, 0);
        check("ab_q", q, 32'h3C);
        check("ab_done", done, 0);
        repeat (W + 2) tick();
        check("ab_q_hold", q, 32'h3C);

        // Reset mid-frame of 0x81
        in_data = 8'h81; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        #3 rst = 1'b1;
        #1;
        check("mr_q", q, 0);
        check("mr_ser", ser_out, 0);
        check("mr_done", done, 0);
        check("mr_ready", in_ready, 1);
        #2 rst = 1'b0;
        tick();

        // Frame after reset, then abort in IDLE blocks a handshake and clears sr only
        in_data = 8'hC3; in_valid = 1'b1; exp_q.push_back(8'hC3);
        tick();
        in_valid = 1'b0;
        repeat (W + 1) tick();
        check("rf_q", q, 32'hC3);
        check("rf_ser", ser_out, 1);
        in_data = 8'h11; in_valid = 1'b1; abort = 1'b1;
        tick();
        in_valid = 1'b0; abort = 1'b0;
        check("ia_ready", in_ready, 1);
        check("ia_ser", ser_out, 0);
        check("ia_q", q, 32'hC3);
        oe_n = 1'b1;
        #1;
        check("oe_no_effect", q, 32'hC3);

        // Random frames, each checked directly and through the scoreboard
        for (int n = 0; n < 6; n++) begin
            f = W'($urandom_range(0, 255));
            in_data = f; in_valid = 1'b1; exp_q.push_back(f);
            tick();
            in_valid = 1'b0;
            repeat (W) tick();
            tick();
            check("rnd_done", done, 1);
            check("rnd_q", q, {24'd0, f});
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
